// File: rtl/if_stage_if.sv
// Fetch-stage port bundle: control/load inputs from the rest of the CPU and
// the IF/ID pipeline register plus load status back out.
interface if_stage_if #(
   parameter int ADDR_W = 6
);
   logic              LoadInstructions;
   logic [31:0]       Instruction;
   logic              Stall;
   logic              BranchTaken;
   logic [31:0]       BranchTarget;
   logic [31:0]       PC;
   logic [31:0]       IFID_Instr;
   logic [31:0]       IFID_PCPlus4;
   logic              IFID_Valid;
   logic [ADDR_W:0]   InstrCount;
   logic              Full;

   modport master (
      output LoadInstructions, Instruction, Stall, BranchTaken, BranchTarget,
      input  PC, IFID_Instr, IFID_PCPlus4, IFID_Valid, InstrCount, Full
   );

   modport slave (
      input  LoadInstructions, Instruction, Stall, BranchTaken, BranchTarget,
      output PC, IFID_Instr, IFID_PCPlus4, IFID_Valid, InstrCount, Full
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: serially loaded instruction memory, PC register and
// IF/ID pipeline register with stall and branch-redirect handling.
module if_stage #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic        clk,
   input  logic        Reset,
   if_stage_if.slave   bus
);
   logic [31:0]     mem_q [DEPTH];

   logic [31:0]     pc_q, pc_d;
   logic [31:0]     ifid_instr_q, ifid_instr_d;
   logic [31:0]     ifid_pcplus4_q, ifid_pcplus4_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic            load_prev_q, load_prev_d;
   logic [ADDR_W:0] instr_count_q, instr_count_d;

   logic              session_start;
   logic              full;
   logic              mem_we;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       loaded_bytes;
   logic [31:0]       fetched;
   logic              unused_target_bits;

   // Redirect targets are word aligned; the low bits are deliberately dropped.
   assign unused_target_bits = ^bus.BranchTarget[1:0];

   assign full          = (instr_count_q == (ADDR_W+1)'(DEPTH));
   assign session_start = bus.LoadInstructions && !load_prev_q;
   assign loaded_bytes  = 32'(instr_count_q) << 2;

   always_comb begin
      fetched = 32'h0;
      if (pc_q < loaded_bytes) begin
         fetched = mem_q[pc_q[ADDR_W+1:2]];
      end
   end

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      pc_d           = pc_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_pcplus4_d = ifid_pcplus4_q;
      ifid_valid_d   = ifid_valid_q;
      instr_count_d  = instr_count_q;
      load_prev_d    = bus.LoadInstructions;
      mem_we         = 1'b0;
      wr_addr        = instr_count_q[ADDR_W-1:0];

      if (bus.LoadInstructions) begin
         ifid_instr_d = 32'h0;
         ifid_valid_d = 1'b0;
         if (session_start) begin
            mem_we        = 1'b1;
            wr_addr       = '0;
            instr_count_d = (ADDR_W+1)'(1);
         end else if (!full) begin
            mem_we        = 1'b1;
            instr_count_d = instr_count_q + (ADDR_W+1)'(1);
         end
      end else if (bus.BranchTaken) begin
         pc_d           = {bus.BranchTarget[31:2], 2'b00};
         ifid_instr_d   = 32'h0;
         ifid_pcplus4_d = 32'h0;
         ifid_valid_d   = 1'b0;
      end else if (!bus.Stall) begin
         ifid_instr_d   = fetched;
         ifid_pcplus4_d = pc_q + 32'd4;
         ifid_valid_d   = 1'b1;
         pc_d           = pc_q + 32'd4;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (Reset) begin
         pc_q           <= 32'h0;
         ifid_instr_q   <= 32'h0;
         ifid_pcplus4_q <= 32'h0;
         ifid_valid_q   <= 1'b0;
         load_prev_q    <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         ifid_instr_q   <= ifid_instr_d;
         ifid_pcplus4_q <= ifid_pcplus4_d;
         ifid_valid_q   <= ifid_valid_d;
         load_prev_q    <= load_prev_d;
      end
   end

   // Load count survives reset so the boot sequence is load, reset, run.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         instr_count_q <= instr_count_d;
      end
   end

   // NOTE: the memory array has no reset; clearing it would forbid a RAM
   // mapping, and reset must not erase a freshly loaded program anyway.
   always_ff @(posedge clk) begin
      if (!Reset && mem_we) begin
         mem_q[wr_addr] <= bus.Instruction;
      end
   end

   assign bus.PC           = pc_q;
   assign bus.IFID_Instr   = ifid_instr_q;
   assign bus.IFID_PCPlus4 = ifid_pcplus4_q;
   assign bus.IFID_Valid   = ifid_valid_q;
   assign bus.InstrCount   = instr_count_q;
   assign bus.Full         = full;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table for load/run/stall/branch plus
// hand-written sequences for memory saturation and reset during a load.
module tb_if_stage;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   typedef struct {
      logic        rst;
      logic        load;
      logic [31:0] instr;
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_valid;
      logic        chk_cnt;
      logic [31:0] e_cnt;
      logic        e_full;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   vec_t vq[$];

   if_stage_if #(.ADDR_W(ADDR_W)) bus ();

   if_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .Reset (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] w(input int i);
      return 32'h2000_0000 + (32'(i + 1) << 16) + 32'd16 + 32'(8 * i);
   endfunction

   function automatic vec_t mk(input logic r, input logic ld, input logic [31:0] ins,
                               input logic st, input logic b, input logic [31:0] t,
                               input logic [31:0] pc, input logic [31:0] fi,
                               input logic [31:0] p4, input logic v,
                               input logic cc, input int cnt, input logic f);
      vec_t x;
      x.rst = r; x.load = ld; x.instr = ins; x.stall = st; x.br = b; x.tgt = t;
      x.e_pc = pc; x.e_instr = fi; x.e_pc4 = p4; x.e_valid = v;
      x.chk_cnt = cc; x.e_cnt = 32'(cnt); x.e_full = f;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic ld, input logic [31:0] ins,
                        input logic st, input logic b, input logic [31:0] t);
      @(negedge clk);
      rst                  = r;
      bus.LoadInstructions = ld;
      bus.Instruction      = ins;
      bus.Stall            = st;
      bus.BranchTaken      = b;
      bus.BranchTarget     = t;
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] fi,
                              input logic [31:0] p4, input logic v);
      check({tag, ".pc"},    bus.PC,                  pc);
      check({tag, ".instr"}, bus.IFID_Instr,          fi);
      check({tag, ".pc4"},   bus.IFID_PCPlus4,        p4);
      check({tag, ".valid"}, 32'(bus.IFID_Valid),     32'(v));
   endtask

   task automatic check_cnt(input string tag, input int cnt, input logic f);
      check({tag, ".count"}, 32'(bus.InstrCount), 32'(cnt));
      check({tag, ".full"},  32'(bus.Full),       32'(f));
   endtask

   initial begin
      rst = 1'b1;
      bus.LoadInstructions = 1'b0;
      bus.Instruction      = '0;
      bus.Stall            = 1'b0;
      bus.BranchTaken      = 1'b0;
      bus.BranchTarget     = '0;

      // Reset, then load 14 words: PC and IF/ID stay idle throughout.
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 14; i++)
         vq.push_back(mk(0, 1, w(i), 0, 0, 0, 0, 0, 0, 0, 1, i + 1, 0));
      // Reset then run past the loaded range: NOP at PC=0x38.
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 0));
      for (int k = 0; k < 15; k++)
         vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'(4*k + 4), (k < 14) ? w(k) : 32'h0,
                         32'(4*k + 4), 1, 1, 14, 0));
      // Reset, fetch two words, stall three cycles at PC=0x8, release.
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 4, w(0), 4, 1, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 8, w(1), 8, 1, 0, 0, 0));
      for (int s = 0; s < 3; s++)
         vq.push_back(mk(0, 0, 0, 1, 0, 0, 8, w(1), 8, 1, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 12, w(2), 12, 1, 0, 0, 0));
      // Branch overrides stall; low target bits forced to zero.
      vq.push_back(mk(0, 0, 0, 1, 1, 32'h7, 4, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 8, w(1), 8, 1, 0, 0, 0));
      // Branch beyond the loaded range fetches a valid NOP.
      vq.push_back(mk(0, 0, 0, 0, 1, 32'h103, 32'h100, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h104, 0, 32'h104, 1, 0, 0, 0));
      // PC wraps modulo 2^32.
      vq.push_back(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 14, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 4, w(0), 4, 1, 0, 0, 0));

      foreach (vq[n]) begin
         drive(vq[n].rst, vq[n].load, vq[n].instr, vq[n].stall, vq[n].br, vq[n].tgt);
         check_state($sformatf("vec%0d", n), vq[n].e_pc, vq[n].e_instr, vq[n].e_pc4,
                     vq[n].e_valid);
         if (vq[n].chk_cnt)
            check_cnt($sformatf("vec%0d", n), int'(vq[n].e_cnt), vq[n].e_full);
      end

      // Load 70 words into a 64-deep memory from PC=4: count saturates, the
      // extra words are dropped, and PC/PCPlus4 hold throughout.
      for (int i = 0; i < 70; i++) begin
         drive(0, 1, 32'hA000_0000 + 32'(i), 0, 0, 0);
         check_state($sformatf("sat%0d", i), 4, 0, 4, 0);
         check_cnt($sformatf("sat%0d", i), (i < 64) ? i + 1 : 64, i >= 63);
      end
      drive(0, 0, 0, 0, 0, 0);
      check_state("sat_run", 8, 32'hA000_0001, 8, 1);
      check_cnt("sat_run", 64, 1);
      drive(0, 0, 0, 0, 1, 32'hFC);
      check_state("sat_br", 32'hFC, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      check_state("sat_last", 32'h100, 32'hA000_003F, 32'h100, 1);
      drive(0, 0, 0, 0, 0, 0);
      check_state("sat_past", 32'h104, 0, 32'h104, 1);

      // Reset on the third load edge: no write, next load restarts at mem[0].
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 32'hB000_0000, 0, 0, 0);
      check_cnt("rml0", 1, 0);
      drive(0, 1, 32'hB000_0001, 0, 0, 0);
      check_cnt("rml1", 2, 0);
      drive(1, 1, 32'hB000_0002, 0, 0, 0);
      check_state("rml_rst", 0, 0, 0, 0);
      check_cnt("rml_rst", 2, 0);
      drive(0, 1, 32'hB000_0003, 0, 0, 0);
      check_cnt("rml_new", 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      check_state("rml_run0", 4, 32'hB000_0003, 4, 1);
      check_cnt("rml_run0", 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      check_state("rml_run1", 8, 0, 8, 1);
      // Reset during run keeps memory and refetches from PC=0.
      drive(1, 0, 0, 0, 0, 0);
      check_state("run_rst", 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      check_state("run_again", 4, 32'hB000_0003, 4, 1);
      check_cnt("run_again", 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
